// File: rtl/cdbus_bus_pkg.sv
// Shared constants for the cdbus physical-layer bus model: topology modes,
// default counter width and the recessive bus level.
package cdbus_bus_pkg;

  localparam int   MODE_HDUPLEX  = 0;
  localparam int   MODE_FDUPLEX  = 1;
  localparam int   CNT_W_DEFAULT = 16;
  localparam logic BUS_IDLE      = 1'b1;

endpackage

// File: rtl/cdbus_delay_line.sv
// Single-bit DEPTH-stage shift register; q is d delayed by exactly DEPTH clocks.
module cdbus_delay_line #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stages <= {DEPTH{RESET_VAL}};
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/cdbus_bus_model.sv
// N-node cdbus interconnect: shared wired-AND half-duplex bus or full-duplex ring,
// with propagation delay, collision detection and statistics. Optional glitch
// injection is enabled with CDBUS_BUSMODEL_GLITCH_EN.
module cdbus_bus_model
  import cdbus_bus_pkg::*;
#(
  parameter int N_NODES = 3,
  parameter int DELAY   = 2,
  parameter int FDUPLEX = MODE_HDUPLEX,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_NODES-1:0] tx,
  input  logic [N_NODES-1:0] tx_en,
  output logic [N_NODES-1:0] rx,
  output logic               bus_level,
  output logic               collision,
  output logic [CNT_W-1:0]   collision_cnt,
  output logic [CNT_W-1:0]   idle_cnt,
  input  logic               cnt_clr
`ifdef CDBUS_BUSMODEL_GLITCH_EN
  ,
  input  logic               glitch,
  output logic [CNT_W-1:0]   glitch_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (DELAY < 1 || N_NODES < 2 || N_NODES > 16) begin : g_param_err
    $fatal(1, "cdbus_bus_model: illegal parameters N_NODES=%0d DELAY=%0d", N_NODES, DELAY);
  end

  logic hd_level;
  logic inject;
  logic any_en_zero;
  logic any_en_one;
  logic coll_cycle;
  logic idle_cycle;

  // Wired-AND: any enabled driver pulling low wins; undriven bus floats recessive.
  always_comb begin
    hd_level = BUS_IDLE;
    for (int i = 0; i < N_NODES; i++) begin
      if (tx_en[i] && !tx[i]) hd_level = 1'b0;
    end
  end

`ifdef CDBUS_BUSMODEL_GLITCH_EN
  assign inject = glitch;
`else
  assign inject = 1'b0;
`endif

  if (FDUPLEX == MODE_HDUPLEX) begin : g_hduplex
    logic line_q;

    cdbus_delay_line #(.DEPTH(DELAY), .RESET_VAL(BUS_IDLE)) u_line (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (hd_level ^ inject),
      .q       (line_q)
    );

    assign rx        = {N_NODES{line_q}};
    assign bus_level = hd_level;
  end else begin : g_fduplex
    for (genvar i = 0; i < N_NODES; i++) begin : g_line
      // Ring: each node hears its successor, so N_NODES=2 degenerates to a swap.
      localparam int SRC = (i + 1) % N_NODES;

      cdbus_delay_line #(.DEPTH(DELAY), .RESET_VAL(BUS_IDLE)) u_line (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (tx[SRC] ^ inject),
        .q       (rx[i])
      );
    end

    assign bus_level = BUS_IDLE;
  end

  // A driven 0 and a driven 1 at once implies two enabled nodes disagreeing.
  assign any_en_zero = |(tx_en & ~tx);
  assign any_en_one  = |(tx_en & tx);
  assign coll_cycle  = (FDUPLEX == MODE_HDUPLEX) && any_en_zero && any_en_one;
  assign idle_cycle  = (FDUPLEX == MODE_HDUPLEX) ? (hd_level && (tx_en == '0)) : (&tx);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      collision     <= 1'b0;
      collision_cnt <= '0;
      idle_cnt      <= '0;
    end else begin
      collision <= coll_cycle;
      if (cnt_clr) begin
        collision_cnt <= '0;
        idle_cnt      <= '0;
      end else begin
        if (coll_cycle && collision_cnt != CNT_MAX) collision_cnt <= collision_cnt + 1'b1;
        if (!idle_cycle) idle_cnt <= '0;
        else if (idle_cnt != CNT_MAX) idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

`ifdef CDBUS_BUSMODEL_GLITCH_EN
  always_ff @(posedge clk) begin
    if (!reset_n || cnt_clr) begin
      glitch_cnt <= '0;
    end else if (glitch && glitch_cnt != CNT_MAX) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cdbus_bus_model.sv
// Bench for cdbus_bus_model: three configurations driven from shared stimulus and
// checked against a cycle history model of the bus rules.
module tb_cdbus_bus_model;

  localparam int NI = 3;
  localparam int N_OF [NI] = '{3, 2, 3};
  localparam int DLY  [NI] = '{2, 1, 3};
  localparam int FD   [NI] = '{0, 1, 1};
  localparam int CW   [NI] = '{4, 4, 8};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] tx;
  logic [15:0] tx_en;
  logic        cnt_clr;
  logic        glitch;

  always #5 clk = ~clk;

  logic [2:0] rx_hd, rx_f3;
  logic [1:0] rx_f2;
  logic       bl_hd, bl_f2, bl_f3;
  logic       col_hd, col_f2, col_f3;
  logic [3:0] ccnt_hd, icnt_hd, ccnt_f2, icnt_f2;
  logic [7:0] ccnt_f3, icnt_f3;
`ifdef CDBUS_BUSMODEL_GLITCH_EN
  logic [3:0] gcnt_hd, gcnt_f2;
  logic [7:0] gcnt_f3;
`endif

  cdbus_bus_model #(.N_NODES(3), .DELAY(2), .FDUPLEX(0), .CNT_W(4)) u_hd (
    .clk(clk), .reset_n(reset_n), .tx(tx[2:0]), .tx_en(tx_en[2:0]), .rx(rx_hd),
    .bus_level(bl_hd), .collision(col_hd), .collision_cnt(ccnt_hd), .idle_cnt(icnt_hd),
    .cnt_clr(cnt_clr)
`ifdef CDBUS_BUSMODEL_GLITCH_EN
    , .glitch(glitch), .glitch_cnt(gcnt_hd)
`endif
  );

  cdbus_bus_model #(.N_NODES(2), .DELAY(1), .FDUPLEX(1), .CNT_W(4)) u_f2 (
    .clk(clk), .reset_n(reset_n), .tx(tx[1:0]), .tx_en(tx_en[1:0]), .rx(rx_f2),
    .bus_level(bl_f2), .collision(col_f2), .collision_cnt(ccnt_f2), .idle_cnt(icnt_f2),
    .cnt_clr(cnt_clr)
`ifdef CDBUS_BUSMODEL_GLITCH_EN
    , .glitch(glitch), .glitch_cnt(gcnt_f2)
`endif
  );

  cdbus_bus_model #(.N_NODES(3), .DELAY(3), .FDUPLEX(1), .CNT_W(8)) u_f3 (
    .clk(clk), .reset_n(reset_n), .tx(tx[2:0]), .tx_en(tx_en[2:0]), .rx(rx_f3),
    .bus_level(bl_f3), .collision(col_f3), .collision_cnt(ccnt_f3), .idle_cnt(icnt_f3),
    .cnt_clr(cnt_clr)
`ifdef CDBUS_BUSMODEL_GLITCH_EN
    , .glitch(glitch), .glitch_cnt(gcnt_f3)
`endif
  );

  logic [15:0] obs_rx [NI];
  logic [15:0] obs_bl [NI];
  logic [15:0] obs_col [NI];
  logic [15:0] obs_ccnt [NI];
  logic [15:0] obs_icnt [NI];

  always_comb begin
    obs_rx[0]   = 16'(rx_hd);   obs_rx[1]   = 16'(rx_f2);   obs_rx[2]   = 16'(rx_f3);
    obs_bl[0]   = 16'(bl_hd);   obs_bl[1]   = 16'(bl_f2);   obs_bl[2]   = 16'(bl_f3);
    obs_col[0]  = 16'(col_hd);  obs_col[1]  = 16'(col_f2);  obs_col[2]  = 16'(col_f3);
    obs_ccnt[0] = 16'(ccnt_hd); obs_ccnt[1] = 16'(ccnt_f2); obs_ccnt[2] = 16'(ccnt_f3);
    obs_icnt[0] = 16'(icnt_hd); obs_icnt[1] = 16'(icnt_f2); obs_icnt[2] = 16'(icnt_f3);
  end

  // Reference model state: history of applied inputs since reset release.
  typedef struct packed {
    logic [15:0] t;
    logic [15:0] te;
    logic        g;
  } samp_t;

  samp_t       hist[$];
  int unsigned e_ccnt [NI];
  int unsigned e_icnt [NI];
  int unsigned e_gcnt [NI];
  logic        e_col  [NI];

  int checks = 0;
  int errors = 0;

  function automatic logic resolve(input logic [15:0] t, input logic [15:0] te, input int n);
    logic lvl = 1'b1;
    for (int i = 0; i < n; i++) if (te[i]) lvl = lvl & t[i];
    return lvl;
  endfunction

  function automatic logic collide(input logic [15:0] t, input logic [15:0] te, input int n);
    int   n_en = 0;
    logic first = 1'b0;
    logic differ = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (te[i]) begin
        if (n_en == 0) first = t[i];
        else if (t[i] != first) differ = 1'b1;
        n_en++;
      end
    end
    return (n_en >= 2) && differ;
  endfunction

  function automatic logic is_idle(input logic [15:0] t, input logic [15:0] te, input int k);
    int n = N_OF[k];
    if (FD[k] == 1) begin
      for (int i = 0; i < n; i++) if (!t[i]) return 1'b0;
      return 1'b1;
    end
    for (int i = 0; i < n; i++) if (te[i]) return 1'b0;
    return resolve(t, te, n);
  endfunction

  function automatic logic [15:0] exp_rx(input int k);
    int          n = N_OF[k];
    logic [15:0] r = '0;
    samp_t       s;
    if (hist.size() < DLY[k]) begin
      for (int i = 0; i < n; i++) r[i] = 1'b1;
      return r;
    end
    s = hist[hist.size() - DLY[k]];
    for (int i = 0; i < n; i++) begin
      if (FD[k] == 1) r[i] = s.t[(i + 1) % n] ^ s.g;
      else            r[i] = resolve(s.t, s.te, n) ^ s.g;
    end
    return r;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v, input int k);
    int unsigned mx = (32'd1 << CW[k]) - 1;
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic check(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] t=%0t observed=%0h expected=%0h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      hist.delete();
      for (int k = 0; k < NI; k++) begin
        e_ccnt[k] = 0; e_icnt[k] = 0; e_gcnt[k] = 0; e_col[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        logic c;
        c = (FD[k] == 0) && collide(tx, tx_en, N_OF[k]);
        e_col[k] = c;
        if (cnt_clr) begin
          e_ccnt[k] = 0; e_icnt[k] = 0; e_gcnt[k] = 0;
        end else begin
          if (c) e_ccnt[k] = sat_inc(e_ccnt[k], k);
          e_icnt[k] = is_idle(tx, tx_en, k) ? sat_inc(e_icnt[k], k) : 0;
          if (glitch) e_gcnt[k] = sat_inc(e_gcnt[k], k);
        end
      end
      hist.push_back('{t: tx, te: tx_en, g: glitch});
      if (hist.size() > 80) void'(hist.pop_front());
    end
  endtask

  // One clock: check the combinational level, clock, update model, check registers.
  task automatic tick();
    #2;
    for (int k = 0; k < NI; k++)
      check("bus_level", k, obs_bl[k], (FD[k] == 1) ? 16'd1 : 16'(resolve(tx, tx_en, N_OF[k])));
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rx", k, obs_rx[k], exp_rx(k));
      check("collision", k, obs_col[k], 16'(e_col[k]));
      check("collision_cnt", k, obs_ccnt[k], 16'(e_ccnt[k]));
      check("idle_cnt", k, obs_icnt[k], 16'(e_icnt[k]));
    end
`ifdef CDBUS_BUSMODEL_GLITCH_EN
    check("glitch_cnt", 0, 16'(gcnt_hd), 16'(e_gcnt[0]));
    check("glitch_cnt", 1, 16'(gcnt_f2), 16'(e_gcnt[1]));
    check("glitch_cnt", 2, 16'(gcnt_f3), 16'(e_gcnt[2]));
`endif
  endtask

  initial begin
    logic [3:0] pat;
    reset_n = 1'b0; tx = 16'h0000; tx_en = 16'hffff; cnt_clr = 1'b0; glitch = 1'b0;
    for (int k = 0; k < NI; k++) begin
      e_ccnt[k] = 0; e_icnt[k] = 0; e_gcnt[k] = 0; e_col[k] = 1'b0;
    end

    // Reset held with all nodes driving 0, then released.
    repeat (3) tick();
    check("reset_rx_hd", 0, obs_rx[0], 16'h0007);
    reset_n = 1'b1;
    repeat (4) tick();
    check("post_reset_rx_hd", 0, obs_rx[0], 16'h0000);

    // Single talker on node 0.
    tx_en = 16'h0001;
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      tx = 16'hfffe | 16'(pat[i]);
      tick();
    end
    tx = 16'hffff;
    repeat (3) tick();

    // Collision, then a second collision coinciding with cnt_clr.
    tx_en = 16'h0003; tx = 16'hfffe & 16'hfffa;
    tx = 16'h0002;
    tick();
    tx_en = 16'h0000; tx = 16'hffff;
    tick();
    check("coll_cnt_first", 0, obs_ccnt[0], 16'd1);
    tick();
    tx_en = 16'h0003; tx = 16'h0002; cnt_clr = 1'b1;
    tick();
    check("coll_cnt_cleared", 0, obs_ccnt[0], 16'd0);
    cnt_clr = 1'b0; tx_en = 16'h0000; tx = 16'hffff;
    repeat (2) tick();

    // Idle saturation, one busy cycle, then counting resumes.
    repeat (20) tick();
    check("idle_saturated", 0, obs_icnt[0], 16'd15);
    tx_en = 16'h0002; tx = 16'hfffd;
    tick();
    check("idle_cleared", 0, obs_icnt[0], 16'd0);
    tx_en = 16'h0000; tx = 16'hffff;
    repeat (3) tick();

    // Full-duplex ring patterns.
    tx = 16'h0001; repeat (4) tick();
    tx = 16'h0006; repeat (4) tick();
    check("ring_n3", 2, obs_rx[2], 16'h0003);

`ifdef CDBUS_BUSMODEL_GLITCH_EN
    tx = 16'hffff; tx_en = 16'h0000;
    glitch = 1'b1; tick();
    glitch = 1'b0; repeat (5) tick();
`endif

    // Randomized traffic with occasional counter clears and resets.
    repeat (600) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 3) begin
        tx_en = 16'h0000; tx = 16'hffff;
      end else if (sel < 7) begin
        tx_en = 16'h0001 << $urandom_range(0, 2);
        tx = 16'($urandom);
      end else begin
        tx_en = 16'($urandom);
        tx = 16'($urandom);
      end
      cnt_clr = ($urandom_range(0, 15) == 0);
      reset_n = ($urandom_range(0, 63) != 0);
`ifdef CDBUS_BUSMODEL_GLITCH_EN
      glitch = ($urandom_range(0, 19) == 0);
`endif
      tick();
    end
    reset_n = 1'b1; cnt_clr = 1'b0; glitch = 1'b0; tx_en = 16'h0000; tx = 16'hffff;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
